// File: rtl/div_share_pkg.sv
// Shared types and helpers for the divider-sharing controller.
// State encoding, response status codes and saturation values.
package div_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CLEAR,
    RESP
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DIVZ    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // Largest positive w-bit two's-complement value, zero-extended.
  function automatic logic [63:0] sat_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit value lives in the low w bits.
  function automatic logic [63:0] sat_neg(input int unsigned w);
    return ~sat_pos(w);
  endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches from last_i+1 with wrap; pointer is held by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               k;
  logic [IDX_W-1:0] kk;
  logic             found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k  = (int'(last_i) + i) % NUM_REQ;
      kk = IDX_W'(k);
      if (!found && req_i[kk]) begin
        found = 1'b1;
        idx_o = kk;
      end
    end
    any_o = found;
    gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider among NUM_REQ requesters.
// Round-robin accept, issue, wait/timeout, clear, respond.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_quotient,
  output logic [DATA_WIDTH-1:0]         rsp_remainder,
  output logic [1:0]                    rsp_status,
  output logic                          div_valid_in,
  output logic [DATA_WIDTH-1:0]         div_dividend,
  output logic [DATA_WIDTH-1:0]         div_divisor,
  input  logic                          div_valid_out,
  input  logic [DATA_WIDTH-1:0]         div_quotient,
  input  logic [DATA_WIDTH-1:0]         div_remainder,
  output logic                          div_clear,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [DATA_WIDTH-1:0] SAT_POS =
    DATA_WIDTH'(sat_pos(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_NEG =
    DATA_WIDTH'(sat_neg(DATA_WIDTH));
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0]  dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0]  dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]  quo_q, quo_d;
  logic [DATA_WIDTH-1:0]  rem_q, rem_d;
  logic [1:0]             sts_q, sts_d;
  logic [CNT_W-1:0]       tmr_q, tmr_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [DATA_WIDTH-1:0]  dvd_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]  dvs_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dvd_a[g] = req_dividend[g*DATA_WIDTH +: DATA_WIDTH];
    assign dvs_a[g] = req_divisor[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sts_q   <= ST_OK;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sts_q   <= sts_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sts_d   = sts_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d = arb_idx;
          dvd_d = dvd_a[arb_idx];
          dvs_d = dvs_a[arb_idx];
          // Zero divisor is answered here and never reaches the divider.
          if (dvs_a[arb_idx] == '0) begin
            quo_d   = dvd_a[arb_idx][DATA_WIDTH-1] ? SAT_NEG : SAT_POS;
            rem_d   = '0;
            sts_d   = ST_DIVZ;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (div_valid_out) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          sts_d   = ST_OK;
          state_d = CLEAR;
        end else if (tmr_q == T_LAST) begin
          quo_d   = '0;
          rem_d   = '0;
          sts_d   = ST_TIMEOUT;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = RESP;
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    div_valid_in = 1'b0;
    div_clear    = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = arb_gnt;
      end
      ISSUE:   div_valid_in = 1'b1;
      CLEAR:   div_clear = 1'b1;
      RESP:    rsp_valid = NUM_REQ'(1) << gnt_q;
      default: ;
    endcase
  end

  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_status    = sts_q;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Shares one iterative fixed-point divider among NUM_REQ requesters, such as the ray-triangle intersection and normalisation units.
- Arbitrates round-robin, issues the operands and waits for completion or timeout.
- Returns the result to the granted requester over a valid/ready response handshake, then clears the divider for the next operation.
- Divide-by-zero never reaches the divider: the block returns a saturated result itself.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 32, operand/result width, signed
- TIMEOUT, 64, maximum cycles in WAIT before the operation is abandoned
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_dividend  in  NUM_REQ*DATA_WIDTH  packed; requester k at [k*DATA_WIDTH +: DATA_WIDTH]
- req_divisor  in  NUM_REQ*DATA_WIDTH  packed, same layout
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_quotient  out  DATA_WIDTH  shared result bus
- rsp_remainder  out  DATA_WIDTH  shared result bus
- rsp_status  out  2  00 ok, 01 divide-by-zero, 10 timeout
- div_valid_in  out  1  start pulse to divider
- div_dividend  out  DATA_WIDTH  divider operand
- div_divisor  out  DATA_WIDTH  divider operand
- div_valid_out  in  1  divider done (level, held until cleared)
- div_quotient  in  DATA_WIDTH  divider result
- div_remainder  in  DATA_WIDTH  divider result
- div_clear  out  1  one-cycle pulse returning divider to idle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - Outputs: all 0.
  - State: IDLE.
  - Internal: rr pointer last_grant = NUM_REQ-1, so requester 0 wins first; operand, result, status and timer registers 0.
- Outstanding operations: one at a time; new requests are accepted only in IDLE.
- IDLE:
  - Winner = first requester with req_valid set, searching from last_grant+1 with wrap.
  - req_ready[winner] = 1 combinationally in the same cycle; the handshake completes there.
  - Captured: operands and grant index.
  - Next state: divisor==0 -> RESP with status 01; otherwise ISSUE.
  - No req_valid: stay in IDLE.
  - A requester may drop req_valid before it is granted.
- Divide-by-zero result:
  - Quotient = 2^(DATA_WIDTH-1)-1 if dividend>=0, else -2^(DATA_WIDTH-1).
  - Remainder = 0.
- ISSUE:
  - div_valid_in = 1 for exactly one cycle; div_dividend/div_divisor driven from the registers.
  - Timer cleared. Next state: WAIT.
- div_dividend/div_divisor: hold the registered operands in every state.
- WAIT:
  - Timer increments each cycle.
  - div_valid_out=1: capture div_quotient/div_remainder, status 00, go to CLEAR.
  - Timer reaches TIMEOUT-1 with no done: quotient 0, remainder 0, status 10, go to CLEAR.
  - Done and timeout in the same cycle: done wins.
- CLEAR: div_clear = 1 for one cycle, then RESP.
- RESP:
  - rsp_valid[grant] = 1, held with result and status stable until rsp_ready[grant].
  - On handshake: last_grant <= grant, then IDLE. rsp_ready of other requesters is ignored.
- Latency:
  - Divide-by-zero: accept at cycle 0, rsp_valid at cycle 1.
  - Normal: accept at cycle 0, div_valid_in at cycle 1, done seen at cycle D, div_clear at D+1, rsp_valid at D+2.
- Fairness: after a requester is served, every other waiting requester is served before it is served again.
- Reset mid-operation: the operation is abandoned with no response and no div_clear; the divider shares reset.
- rsp_quotient/rsp_remainder/rsp_status: registered; meaningful only while rsp_valid is high.

Decomposition:
- Package div_share_pkg:
  - state enum {IDLE, ISSUE, WAIT, CLEAR, RESP}
  - status constants ST_OK, ST_DIVZ, ST_TIMEOUT
  - saturation constants SAT_POS, SAT_NEG (DATA_WIDTH-parameterised function)
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational; the pointer register lives in div_share_ctrl.

Test Plan:
- Single request, model divider with 33-cycle latency: req0 dividend 0x00000C00, divisor 0x00000400, model returns quotient 0x00000C00, remainder 0 -> req_ready[0] at cycle 0, div_valid_in at 1, div_clear at 35, rsp_valid[0] at 36, status 00.
- All four req_valid held high, rsp_ready always 1 -> grant order 0,1,2,3,0; each operation passes through a single div_valid_in pulse.
- Divide-by-zero: req2 dividend -5, divisor 0 -> rsp_valid[2] one cycle after accept, quotient 0x80000000, remainder 0, status 01, div_valid_in never asserted. Repeat with dividend +5 -> quotient 0x7FFFFFFF.
- Timeout: model never asserts done -> after 64 WAIT cycles, div_clear pulse, then rsp status 10, quotient 0, remainder 0.
- Backpressure: rsp_ready[1] low for 10 cycles -> rsp_valid[1] and data stable; no new req_ready while req0 waits; on release, the next grant goes to requester 2 or the next valid after 1.
- Async reset asserted during WAIT -> all outputs 0 immediately, busy 0; first grant after reset goes to requester 0.
